// File: rtl/pipeline_mem_stage_hs_pkg.sv
// Shared definitions for the MEM stage: access-size codes, FSM encodings,
// byte-enable patterns and the load-extension helper.
package pipeline_mem_stage_hs_pkg;

   localparam logic [1:0] DT_WORD = 2'b00;
   localparam logic [1:0] DT_HALF = 2'b01;
   localparam logic [1:0] DT_BYTE = 2'b10;
   localparam logic [1:0] DT_RSVD = 2'b11;

   localparam logic [0:0] ST_IDLE = 1'b0;
   localparam logic [0:0] ST_REQ  = 1'b1;

   localparam logic [3:0] BE_WORD    = 4'b1111;
   localparam logic [3:0] BE_HALF_LO = 4'b0011;
   localparam logic [3:0] BE_HALF_HI = 4'b1100;
   localparam logic [3:0] BE_BYTE0   = 4'b0001;

   // Access attributes captured at accept and held for the whole request.
   typedef struct packed {
      logic       we;
      logic [1:0] dtype;
      logic       is_unsigned;
      logic [1:0] off;
   } req_ctl_t;

   function automatic logic [31:0] extend_load(input logic [15:0] lane,
                                               input logic        is_half,
                                               input logic        is_unsigned);
      logic [31:0] res;
      if (is_half) begin
         res = is_unsigned ? {16'h0000, lane} : {{16{lane[15]}}, lane};
      end else begin
         res = is_unsigned ? {24'h00_0000, lane[7:0]} : {{24{lane[7]}}, lane[7:0]};
      end
      return res;
   endfunction

endpackage

// File: rtl/pipeline_mem_stage_hs_if.sv
// Bundle of the MEM stage's upstream handshake, data-memory bus and MEM/WB outputs.
// slave = the stage itself, master = the surrounding pipeline and memory.
interface pipeline_mem_stage_hs_if #(
   parameter int ADDR_W = 11
);
   logic              in_valid;
   logic              in_ready;
   logic              dmem_enable;
   logic              dmem_write_enable;
   logic [1:0]        dmem_type;
   logic              dmem_unsigned;
   logic [31:0]       alu_result_in;
   logic [31:0]       rt_data;
   logic [4:0]        rd_write_address;
   logic              rd_select;
   logic              rd_write_enable;

   logic              mem_req;
   logic              mem_we;
   logic [ADDR_W-1:0] mem_addr;
   logic [3:0]        mem_be;
   logic [31:0]       mem_wdata;
   logic              mem_ack;
   logic [31:0]       mem_rdata;

   logic              out_valid;
   logic              out_ready;
   logic [4:0]        rd_write_address_out;
   logic              rd_select_out;
   logic              rd_write_enable_out;
   logic [31:0]       alu_result_out;
   logic [31:0]       dmem_data_out;
   logic              misalign_out;
   logic              bus_error_out;

   modport master (
      output in_valid, dmem_enable, dmem_write_enable, dmem_type, dmem_unsigned,
             alu_result_in, rt_data, rd_write_address, rd_select, rd_write_enable,
             mem_ack, mem_rdata, out_ready,
      input  in_ready, mem_req, mem_we, mem_addr, mem_be, mem_wdata,
             out_valid, rd_write_address_out, rd_select_out, rd_write_enable_out,
             alu_result_out, dmem_data_out, misalign_out, bus_error_out
   );

   modport slave (
      input  in_valid, dmem_enable, dmem_write_enable, dmem_type, dmem_unsigned,
             alu_result_in, rt_data, rd_write_address, rd_select, rd_write_enable,
             mem_ack, mem_rdata, out_ready,
      output in_ready, mem_req, mem_we, mem_addr, mem_be, mem_wdata,
             out_valid, rd_write_address_out, rd_select_out, rd_write_enable_out,
             alu_result_out, dmem_data_out, misalign_out, bus_error_out
   );

endinterface

// File: rtl/pipeline_mem_stage_hs_lane_align.sv
// Combinational lane steering: byte enables and replicated store data from
// offset/size, load lane select with sign/zero extension, misalignment detect.
module pipeline_mem_stage_hs_lane_align (
   input  logic [1:0]  dtype,
   input  logic [1:0]  off,
   input  logic        is_unsigned,
   input  logic [31:0] st_data,
   input  logic [31:0] ld_word,
   output logic [3:0]  be,
   output logic [31:0] wdata,
   output logic [31:0] ld_data,
   output logic        misalign
);
   import pipeline_mem_stage_hs_pkg::*;

   logic [31:0] shifted_s;
   logic [15:0] half_s;

   assign shifted_s = ld_word >> {off, 3'b000};
   assign half_s    = off[1] ? ld_word[31:16] : ld_word[15:0];

   // Per-size lane decode; the reserved code behaves as a word access.
   always_comb begin
      be       = 4'b0000;
      wdata    = 32'h0000_0000;
      ld_data  = 32'h0000_0000;
      misalign = 1'b0;
      case (dtype)
         DT_BYTE: begin
            be       = BE_BYTE0 << off;
            wdata    = {4{st_data[7:0]}};
            ld_data  = extend_load({8'h00, shifted_s[7:0]}, 1'b0, is_unsigned);
            misalign = 1'b0;
         end
         DT_HALF: begin
            be       = off[1] ? BE_HALF_HI : BE_HALF_LO;
            wdata    = {2{st_data[15:0]}};
            ld_data  = extend_load(half_s, 1'b1, is_unsigned);
            misalign = off[0];
         end
         default: begin
            be       = BE_WORD;
            wdata    = st_data;
            ld_data  = ld_word;
            misalign = (off != 2'b00);
         end
      endcase
   end

endmodule

// File: rtl/pipeline_mem_stage_hs.sv
// MEM stage: accepts EX/MEM payloads, runs one variable-latency data-memory
// request at a time with timeout, and presents results in the MEM/WB register.
module pipeline_mem_stage_hs #(
   parameter logic [31:0] BASE_ADDR = 32'h1001_0000,
   parameter int          ADDR_W    = 11,
   parameter int          TIMEOUT   = 16
) (
   input logic                   clock,
   input logic                   reset,
   pipeline_mem_stage_hs_if.slave bus
);
   import pipeline_mem_stage_hs_pkg::*;

   localparam int                CNT_W      = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
   localparam logic [CNT_W-1:0]  CNT_LAST   = (TIMEOUT > 0) ? CNT_W'(TIMEOUT - 1) : {CNT_W{1'b0}};
   localparam logic              TIMEOUT_EN = (TIMEOUT != 0);

   logic [0:0]        state_r;
   logic [CNT_W-1:0]  wait_cnt_r;
   req_ctl_t          req_ctl_r;
   logic [ADDR_W-1:0] mem_addr_r;
   logic [3:0]        mem_be_r;
   logic [31:0]       mem_wdata_r;

   logic              out_valid_r;
   logic [4:0]        rd_addr_out_r;
   logic              rd_sel_out_r;
   logic              rd_we_out_r;
   logic [31:0]       alu_out_r;
   logic [31:0]       dmem_data_r;
   logic              misalign_r;
   logic              bus_err_r;

   logic              in_ready_s;
   logic              accept_s;
   logic              misalign_s;
   logic              timeout_s;
   logic [ADDR_W-1:0] word_idx_s;
   logic [1:0]        lane_type_s;
   logic [1:0]        lane_off_s;
   logic              lane_uns_s;
   logic [3:0]        be_s;
   logic [31:0]       wdata_s;
   logic [31:0]       ld_data_s;
   logic              mis_raw_s;

   assign in_ready_s = (state_r == ST_IDLE) && (!out_valid_r || bus.out_ready);
   assign accept_s   = bus.in_valid && in_ready_s;
   assign misalign_s = bus.dmem_enable && mis_raw_s;
   assign timeout_s  = TIMEOUT_EN && (wait_cnt_r == CNT_LAST);
   assign word_idx_s = ADDR_W'((bus.alu_result_in - BASE_ADDR) >> 2);

   // The lane decoder sees the incoming op while idle and the held request while waiting.
   always_comb begin
      if (state_r == ST_REQ) begin
         lane_type_s = req_ctl_r.dtype;
         lane_off_s  = req_ctl_r.off;
         lane_uns_s  = req_ctl_r.is_unsigned;
      end else begin
         lane_type_s = bus.dmem_type;
         lane_off_s  = bus.alu_result_in[1:0];
         lane_uns_s  = bus.dmem_unsigned;
      end
   end

   pipeline_mem_stage_hs_lane_align u_lane_align (
      .dtype       (lane_type_s),
      .off         (lane_off_s),
      .is_unsigned (lane_uns_s),
      .st_data     (bus.rt_data),
      .ld_word     (bus.mem_rdata),
      .be          (be_s),
      .wdata       (wdata_s),
      .ld_data     (ld_data_s),
      .misalign    (mis_raw_s)
   );

   // FSM, wait counter, request fields and MEM/WB register.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_r       <= ST_IDLE;
         wait_cnt_r    <= {CNT_W{1'b0}};
         req_ctl_r     <= '{we: 1'b0, dtype: 2'b00, is_unsigned: 1'b0, off: 2'b00};
         mem_addr_r    <= {ADDR_W{1'b0}};
         mem_be_r      <= 4'b0000;
         mem_wdata_r   <= 32'h0000_0000;
         out_valid_r   <= 1'b0;
         rd_addr_out_r <= 5'd0;
         rd_sel_out_r  <= 1'b0;
         rd_we_out_r   <= 1'b0;
         alu_out_r     <= 32'h0000_0000;
         dmem_data_r   <= 32'h0000_0000;
         misalign_r    <= 1'b0;
         bus_err_r     <= 1'b0;
      end else begin
         case (state_r)
            ST_IDLE: begin
               if (out_valid_r && bus.out_ready) begin
                  out_valid_r <= 1'b0;
               end
               if (accept_s) begin
                  rd_addr_out_r <= bus.rd_write_address;
                  rd_sel_out_r  <= bus.rd_select;
                  alu_out_r     <= bus.alu_result_in;
                  dmem_data_r   <= 32'h0000_0000;
                  bus_err_r     <= 1'b0;
                  misalign_r    <= misalign_s;
                  wait_cnt_r    <= {CNT_W{1'b0}};
                  if (bus.dmem_enable && !misalign_s) begin
                     // Payload waits in the (empty) output register until ack or timeout.
                     state_r     <= ST_REQ;
                     rd_we_out_r <= bus.rd_write_enable;
                     req_ctl_r   <= '{we: bus.dmem_write_enable, dtype: bus.dmem_type,
                                      is_unsigned: bus.dmem_unsigned, off: bus.alu_result_in[1:0]};
                     mem_addr_r  <= word_idx_s;
                     mem_be_r    <= be_s;
                     mem_wdata_r <= wdata_s;
                  end else begin
                     out_valid_r <= 1'b1;
                     rd_we_out_r <= bus.rd_write_enable && !misalign_s;
                  end
               end
            end
            ST_REQ: begin
               if (bus.mem_ack) begin
                  state_r     <= ST_IDLE;
                  out_valid_r <= 1'b1;
                  wait_cnt_r  <= {CNT_W{1'b0}};
                  dmem_data_r <= req_ctl_r.we ? 32'h0000_0000 : ld_data_s;
               end else if (timeout_s) begin
                  state_r     <= ST_IDLE;
                  out_valid_r <= 1'b1;
                  wait_cnt_r  <= {CNT_W{1'b0}};
                  bus_err_r   <= 1'b1;
                  rd_we_out_r <= 1'b0;
                  dmem_data_r <= 32'h0000_0000;
               end else begin
                  wait_cnt_r  <= wait_cnt_r + CNT_W'(1'b1);
               end
            end
            default: begin
               state_r <= ST_IDLE;
            end
         endcase
      end
   end

   assign bus.in_ready             = in_ready_s;
   assign bus.mem_req              = (state_r == ST_REQ);
   assign bus.mem_we               = req_ctl_r.we;
   assign bus.mem_addr             = mem_addr_r;
   assign bus.mem_be               = mem_be_r;
   assign bus.mem_wdata            = mem_wdata_r;
   assign bus.out_valid            = out_valid_r;
   assign bus.rd_write_address_out = rd_addr_out_r;
   assign bus.rd_select_out        = rd_sel_out_r;
   assign bus.rd_write_enable_out  = rd_we_out_r;
   assign bus.alu_result_out       = alu_out_r;
   assign bus.dmem_data_out        = dmem_data_r;
   assign bus.misalign_out         = misalign_r;
   assign bus.bus_error_out        = bus_err_r;

endmodule

// File: tb/tb_pipeline_mem_stage_hs.sv
// Randomised bench for pipeline_mem_stage_hs against a byte-level reference
// model of the data memory and the load/store lane rules.
module tb_pipeline_mem_stage_hs;

   localparam logic [31:0] BASE    = 32'h1001_0000;
   localparam int          ADDR_W  = 11;
   localparam int          TIMEOUT = 4;
   localparam int          WORDS   = 2048;

   logic clock = 1'b0;
   logic reset = 1'b1;
   always #5 clock = ~clock;

   pipeline_mem_stage_hs_if #(.ADDR_W(ADDR_W)) ifc ();

   pipeline_mem_stage_hs #(.BASE_ADDR(BASE), .ADDR_W(ADDR_W), .TIMEOUT(TIMEOUT)) dut (
      .clock (clock),
      .reset (reset),
      .bus   (ifc)
   );

   int          total = 0;
   int          bad   = 0;
   logic [31:0] mem_model [0:WORDS-1];

   task automatic drive_idle();
      ifc.in_valid          = 1'b0;
      ifc.dmem_enable       = 1'b0;
      ifc.dmem_write_enable = 1'b0;
      ifc.dmem_type         = 2'b00;
      ifc.dmem_unsigned     = 1'b0;
      ifc.alu_result_in     = 32'h0;
      ifc.rt_data           = 32'h0;
      ifc.rd_write_address  = 5'd0;
      ifc.rd_select         = 1'b0;
      ifc.rd_write_enable   = 1'b0;
      ifc.mem_ack           = 1'b0;
      ifc.mem_rdata         = 32'h0;
      ifc.out_ready         = 1'b1;
   endtask

   // One transaction: the expected result comes from the size/offset rules
   // applied to the reference memory. ack_after<0 means the memory never answers.
   task automatic do_op(input logic en, input logic we, input logic [1:0] typ, input logic uns,
                        input logic [31:0] addr, input logic [31:0] rt, input logic [4:0] rd,
                        input logic sel, input logic rwe, input int ack_after, input string tag);
      int          size, off, idx, nreq, lat, e_lat, e_nreq;
      logic        mis, issue, e_berr, got, req_bad;
      logic [3:0]  e_be;
      logic [31:0] e_wdata, e_data, rdata, mask;
      off    = int'(addr % 32'd4);
      size   = (typ == 2'b10) ? 1 : (typ == 2'b01) ? 2 : 4;
      idx    = int'(((addr - BASE) >> 2) % 32'd2048);
      mis    = en && ((off % size) != 0);
      issue  = en && !mis;
      e_berr = issue && (ack_after < 0 || ack_after >= TIMEOUT);
      e_be   = 4'(((1 << size) - 1) << off);
      for (int i = 0; i < 4; i++) e_wdata[8*i +: 8] = rt[8*(i % size) +: 8];
      rdata  = mem_model[idx];
      mask   = (size == 4) ? 32'hFFFF_FFFF : ((32'h1 << (8 * size)) - 32'h1);
      e_data = (rdata >> (8 * off)) & mask;
      if (size < 4 && !uns && e_data[8*size-1]) e_data = e_data | ~mask;
      if (!issue || we || e_berr) e_data = 32'h0;
      e_lat  = !issue ? 1 : (e_berr ? TIMEOUT + 1 : ack_after + 2);
      e_nreq = !issue ? 0 : (e_berr ? TIMEOUT : ack_after + 1);

      @(negedge clock);
      total++;
      if (ifc.in_ready !== 1'b1) begin
         bad++; $display("FAIL %s in_ready_before: got %b want 1", tag, ifc.in_ready);
      end
      ifc.in_valid = 1'b1; ifc.dmem_enable = en; ifc.dmem_write_enable = we;
      ifc.dmem_type = typ; ifc.dmem_unsigned = uns; ifc.alu_result_in = addr;
      ifc.rt_data = rt; ifc.rd_write_address = rd; ifc.rd_select = sel; ifc.rd_write_enable = rwe;
      @(posedge clock); #1;
      drive_idle();

      nreq = 0; lat = 0; got = 1'b0; req_bad = 1'b0;
      for (int c = 0; c < 20 && !got; c++) begin
         @(negedge clock);
         ifc.mem_ack = 1'b0;
         lat++;
         if (ifc.out_valid) begin
            got = 1'b1;
         end else if (ifc.mem_req) begin
            nreq++;
            if (ifc.mem_we !== we || ifc.mem_addr !== ADDR_W'(idx) || ifc.mem_be !== e_be ||
                (we && ifc.mem_wdata !== e_wdata)) begin
               req_bad = 1'b1;
               $display("FAIL %s req_fields: got we=%b addr=%0d be=%b wdata=%h want we=%b addr=%0d be=%b wdata=%h",
                        tag, ifc.mem_we, ifc.mem_addr, ifc.mem_be, ifc.mem_wdata, we, idx, e_be, e_wdata);
            end
            if (ack_after >= 0 && nreq == ack_after + 1) begin
               ifc.mem_ack   = 1'b1;
               ifc.mem_rdata = rdata;
            end
         end
      end
      ifc.mem_ack = 1'b0;

      total++;
      if (!got) begin
         bad++; $display("FAIL %s out_valid_timeout: got none within 20 cycles want valid", tag);
      end else begin
         if (issue) begin
            total++;
            if (req_bad) bad++;
         end
         total++;
         if (lat !== e_lat || nreq !== e_nreq) begin
            bad++; $display("FAIL %s latency: got lat=%0d req_cycles=%0d want lat=%0d req_cycles=%0d",
                            tag, lat, nreq, e_lat, e_nreq);
         end
         total++;
         if (ifc.dmem_data_out !== e_data) begin
            bad++; $display("FAIL %s dmem_data_out: got %h want %h", tag, ifc.dmem_data_out, e_data);
         end
         total++;
         if (ifc.misalign_out !== mis || ifc.bus_error_out !== e_berr ||
             ifc.rd_write_enable_out !== (rwe && !mis && !e_berr)) begin
            bad++; $display("FAIL %s flags: got mis=%b berr=%b rwe=%b want mis=%b berr=%b rwe=%b", tag,
                            ifc.misalign_out, ifc.bus_error_out, ifc.rd_write_enable_out,
                            mis, e_berr, rwe && !mis && !e_berr);
         end
         total++;
         if (ifc.alu_result_out !== addr || ifc.rd_write_address_out !== rd || ifc.rd_select_out !== sel) begin
            bad++; $display("FAIL %s passthrough: got alu=%h rd=%0d sel=%b want alu=%h rd=%0d sel=%b", tag,
                            ifc.alu_result_out, ifc.rd_write_address_out, ifc.rd_select_out, addr, rd, sel);
         end
         total++;
         if (ifc.mem_req !== 1'b0 || ifc.in_ready !== 1'b1) begin
            bad++; $display("FAIL %s idle_after: got mem_req=%b in_ready=%b want 0 1", tag, ifc.mem_req, ifc.in_ready);
         end
      end
      if (issue && we && !e_berr) begin
         for (int i = 0; i < 4; i++) if (e_be[i]) mem_model[idx][8*i +: 8] = e_wdata[8*i +: 8];
      end
   endtask

   task automatic test_reset();
      #12;
      total++;
      if ({ifc.out_valid, ifc.mem_req, ifc.misalign_out, ifc.bus_error_out, ifc.dmem_data_out,
           ifc.mem_addr, ifc.mem_be, ifc.alu_result_out, ifc.rd_write_enable_out} !== '0) begin
         bad++; $display("FAIL reset_outputs: got out_valid=%b mem_req=%b data=%h addr=%0d be=%b want all 0",
                         ifc.out_valid, ifc.mem_req, ifc.dmem_data_out, ifc.mem_addr, ifc.mem_be);
      end
      @(negedge clock);
      reset = 1'b0;
      @(negedge clock);
      total++;
      if (ifc.in_ready !== 1'b1) begin
         bad++; $display("FAIL reset_in_ready: got %b want 1", ifc.in_ready);
      end
   endtask

   task automatic test_directed();
      mem_model[2] = 32'hDEAD_BEEF;
      mem_model[0] = 32'h80AA_BBCC;
      do_op(1'b1, 1'b0, 2'b00, 1'b0, 32'h1001_0008, 32'h0, 5'd3, 1'b1, 1'b1, 3, "lw_ack3");
      do_op(1'b1, 1'b0, 2'b10, 1'b0, 32'h1001_0003, 32'h0, 5'd4, 1'b1, 1'b1, 1, "lb_neg");
      do_op(1'b1, 1'b0, 2'b10, 1'b1, 32'h1001_0003, 32'h0, 5'd5, 1'b1, 1'b1, 0, "lbu");
      do_op(1'b1, 1'b1, 2'b01, 1'b0, 32'h1001_0006, 32'h1234_ABCD, 5'd6, 1'b0, 1'b0, 2, "sh_hi");
      do_op(1'b1, 1'b0, 2'b01, 1'b0, 32'h1001_0004, 32'h0, 5'd7, 1'b1, 1'b1, 0, "lh_after_sh");
      do_op(1'b1, 1'b0, 2'b00, 1'b0, 32'h1001_0002, 32'h0, 5'd8, 1'b1, 1'b1, 0, "lw_misalign");
      do_op(1'b1, 1'b0, 2'b01, 1'b1, 32'h1001_0005, 32'h0, 5'd9, 1'b1, 1'b1, 0, "lhu_misalign");
      do_op(1'b0, 1'b0, 2'b00, 1'b0, 32'h0000_1234, 32'h0, 5'd10, 1'b0, 1'b1, 0, "alu_op");
   endtask

   task automatic test_timeout();
      do_op(1'b1, 1'b0, 2'b00, 1'b0, 32'h1001_0010, 32'h0, 5'd11, 1'b1, 1'b1, -1, "lw_timeout");
      do_op(1'b1, 1'b1, 2'b11, 1'b0, 32'h1001_0020, 32'hCAFE_F00D, 5'd12, 1'b0, 1'b1, -1, "sw_rsvd_timeout");
   endtask

   task automatic test_random();
      logic [31:0] addr;
      for (int n = 0; n < 60; n++) begin
         if ($urandom_range(0, 7) == 0) addr = $urandom;
         else addr = BASE + 32'($urandom_range(0, WORDS - 1)) * 32'd4 + 32'($urandom_range(0, 3));
         do_op(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)),
               1'($urandom_range(0, 1)), addr, $urandom, 5'($urandom_range(0, 31)),
               1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), $urandom_range(0, 5), "random");
      end
   endtask

   task automatic test_back_pressure();
      @(negedge clock);
      ifc.out_ready = 1'b0;
      ifc.in_valid = 1'b1; ifc.alu_result_in = 32'h0000_AAAA; ifc.rd_write_address = 5'd17;
      ifc.rd_write_enable = 1'b1;
      @(posedge clock); #1;
      ifc.alu_result_in = 32'h0000_BBBB; ifc.rd_write_address = 5'd18;
      for (int c = 0; c < 5; c++) begin
         @(negedge clock);
         total++;
         if (ifc.out_valid !== 1'b1 || ifc.alu_result_out !== 32'h0000_AAAA ||
             ifc.rd_write_address_out !== 5'd17 || ifc.in_ready !== 1'b0) begin
            bad++; $display("FAIL hold_cycle%0d: got valid=%b alu=%h rd=%0d in_ready=%b want 1 0000aaaa 17 0",
                            c, ifc.out_valid, ifc.alu_result_out, ifc.rd_write_address_out, ifc.in_ready);
         end
      end
      ifc.out_ready = 1'b1;
      @(posedge clock); #1;
      ifc.in_valid = 1'b0;
      @(negedge clock);
      total++;
      if (ifc.out_valid !== 1'b1 || ifc.alu_result_out !== 32'h0000_BBBB || ifc.rd_write_address_out !== 5'd18) begin
         bad++; $display("FAIL hold_release: got valid=%b alu=%h rd=%0d want 1 0000bbbb 18",
                         ifc.out_valid, ifc.alu_result_out, ifc.rd_write_address_out);
      end
      drive_idle();
      @(negedge clock);
   endtask

   task automatic test_reset_mid_req();
      int waited;
      @(negedge clock);
      ifc.in_valid = 1'b1; ifc.dmem_enable = 1'b1; ifc.alu_result_in = 32'h1001_0040;
      ifc.rd_write_address = 5'd21; ifc.rd_write_enable = 1'b1;
      @(posedge clock); #1;
      drive_idle();
      waited = 0;
      while (ifc.mem_req !== 1'b1 && waited < 10) begin
         @(negedge clock);
         waited++;
      end
      total++;
      if (ifc.mem_req !== 1'b1) begin
         bad++; $display("FAIL midreq_start: got mem_req=%b want 1", ifc.mem_req);
      end
      #2 reset = 1'b1;
      #1;
      total++;
      if ({ifc.out_valid, ifc.mem_req, ifc.mem_addr, ifc.mem_be, ifc.alu_result_out,
           ifc.rd_write_enable_out, ifc.dmem_data_out} !== '0) begin
         bad++; $display("FAIL midreq_reset: got mem_req=%b addr=%0d be=%b alu=%h want all 0",
                         ifc.mem_req, ifc.mem_addr, ifc.mem_be, ifc.alu_result_out);
      end
      @(negedge clock);
      reset = 1'b0;
      ifc.mem_ack = 1'b1; ifc.mem_rdata = 32'h1234_5678;
      for (int c = 0; c < 2; c++) begin
         @(negedge clock);
         total++;
         if (ifc.out_valid !== 1'b0 || ifc.mem_req !== 1'b0 || ifc.in_ready !== 1'b1) begin
            bad++; $display("FAIL stray_ack: got valid=%b mem_req=%b in_ready=%b want 0 0 1",
                            ifc.out_valid, ifc.mem_req, ifc.in_ready);
         end
      end
      ifc.mem_ack = 1'b0;
   endtask

   initial begin
      drive_idle();
      for (int i = 0; i < WORDS; i++) mem_model[i] = $urandom;
      test_reset();
      test_directed();
      test_timeout();
      test_random();
      test_back_pressure();
      test_reset_mid_req();
      do_op(1'b1, 1'b0, 2'b00, 1'b0, 32'h1001_0008, 32'h0, 5'd1, 1'b1, 1'b1, 0, "lw_after_reset");
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
